bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 16: maximum consecutive cycles DMA may hold the bus per grant (legal 2..255).
REQ-002 Parameter CPU_MIN, default 4: cooldown cycles guaranteed to CPU after each DMA release (legal 0..255).
REQ-003 Port clock  input  1  system clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port dma_req  input  1  DMA requests ownership of address_Bus/Data_Bus; level, held until dma_done or release.
REQ-006 Port dma_done  input  1  one-cycle pulse from DMA, transfer complete.
REQ-007 Port cpu_idle  input  1  CPU has no bus cycle in progress; safe to take bus.
REQ-008 Port ADE  output  1  1 = CPU may drive bus; 0 = CPU must tri-state and stall bus access.
REQ-009 Port dma_grant  output  1  1 = DMA owns bus and may drive Read_DMA/Write_DMA.
REQ-010 Port preempt  output  1  one-cycle pulse, DMA grant revoked by burst limit.
REQ-011 Port state  output  2  current FSM state, debug.

Function
REQ-012 The block SHALL implement a 4-state FSM: CPU_BUS=00, HANDOVER=01, DMA_BUS=10, RETURN=11; all outputs registered (Moore).
REQ-013 The block SHALL drive ADE=1 only in CPU_BUS and dma_grant=1 only in DMA_BUS; ADE and dma_grant SHALL never be 1 in the same cycle.
REQ-014 CPU_BUS SHALL go to HANDOVER when dma_req=1 and cool_cnt=0; otherwise stay, decrementing cool_cnt if nonzero.
REQ-015 HANDOVER SHALL go to DMA_BUS when cpu_idle=1 and dma_req=1, to CPU_BUS (cool_cnt unchanged at 0) when dma_req=0, else stay.
REQ-016 On entry to DMA_BUS burst_cnt SHALL be cleared to 0 and SHALL increment every cycle spent in DMA_BUS (8-bit, no wrap reached since BURST_MAX<=255).
REQ-017 DMA_BUS SHALL go to RETURN when dma_done=1, or dma_req=0, or burst_cnt=BURST_MAX-1; dma_grant is therefore high at most BURST_MAX cycles.
REQ-018 preempt SHALL pulse 1 cycle, coincident with first RETURN cycle, only when exit was caused by burst limit with dma_done=0 and dma_req=1.
REQ-019 Simultaneous dma_done and burst limit SHALL count as normal completion (preempt=0).
REQ-020 RETURN SHALL last exactly one cycle (ADE=0, dma_grant=0 dead cycle), then go to CPU_BUS loading cool_cnt=CPU_MIN.
REQ-021 Latency: dma_req sampled at edge k (CPU_BUS, cool_cnt=0) -> ADE=0 after k; cpu_idle=1 at edge k+1 -> dma_grant=1 after k+1.
REQ-022 Release latency: dma_done at edge m -> dma_grant=0 after m, ADE=1 after m+1.
REQ-023 After any release, ADE SHALL stay high at least CPU_MIN+1 cycles before the next HANDOVER regardless of dma_req.
REQ-024 dma_done outside DMA_BUS SHALL be ignored.
REQ-025 dma_req held high after a preempt SHALL re-arbitrate normally after cooldown (no request latching needed).

Reset
REQ-026 rst_n=0 SHALL immediately force state=CPU_BUS, ADE=1, dma_grant=0, preempt=0, burst_cnt=0, cool_cnt=0, including mid-burst.
REQ-027 First transition after rst_n deassert SHALL occur no earlier than the first rising clock edge with rst_n=1.

Verification
REQ-028 Basic: dma_req=1, cpu_idle=1, dma_done pulse on 5th grant cycle -> ADE 1->0 one cycle before dma_grant=1; grant 5 cycles; 1 dead cycle; ADE=1; preempt=0.
REQ-029 Burst limit: dma_req held high, no dma_done, BURST_MAX=16 -> dma_grant high exactly 16 cycles, preempt 1-cycle pulse, ADE high 5 cycles (CPU_MIN=4) then HANDOVER again.
REQ-030 CPU busy: cpu_idle=0 for 7 cycles after request -> state=01 held 7+ cycles, ADE=0, dma_grant=0; grant 1 cycle after cpu_idle rises.
REQ-031 Abort: dma_req drops while in HANDOVER -> return to CPU_BUS next cycle, ADE=1, no grant, no cooldown.
REQ-032 Async reset mid-burst (grant cycle 3) -> ADE=1, dma_grant=0, state=00 before next clock edge.
REQ-033 Collision: dma_done and burst_cnt=15 same edge -> RETURN with preempt=0; checker asserts ADE&dma_grant never 1 throughout all tests.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA bus ownership FSM with a DMA burst limit and a guaranteed CPU cooldown.
// Outputs are registered from the next state, so ADE and dma_grant are never high together.
module bus_arbiter #(
    parameter int BURST_MAX = 16,
    parameter int CPU_MIN   = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       dma_req,
    input  logic       dma_done,
    input  logic       cpu_idle,
    output logic       ADE,
    output logic       dma_grant,
    output logic       preempt,
    output logic [1:0] state
);
    localparam logic [1:0] CPU_BUS  = 2'b00;
    localparam logic [1:0] HANDOVER = 2'b01;
    localparam logic [1:0] DMA_BUS  = 2'b10;
    localparam logic [1:0] RETURN   = 2'b11;
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
    localparam logic [7:0] COOL_LOAD  = 8'(CPU_MIN);
    logic [1:0] next_state;
    logic [7:0] burst_cnt;
    logic [7:0] cool_cnt;
    logic       burst_end;
    always_comb begin
        burst_end  = burst_cnt == BURST_LAST;
        next_state = (state == CPU_BUS)  ? ((dma_req && cool_cnt == 8'd0) ? HANDOVER : CPU_BUS) :
                     (state == HANDOVER) ? (!dma_req ? CPU_BUS : (cpu_idle ? DMA_BUS : HANDOVER)) :
                     (state == DMA_BUS)  ? ((dma_done || !dma_req || burst_end) ? RETURN : DMA_BUS) :
                                           CPU_BUS;
    end
    // preempt only flags a forced revocation; a coincident dma_done is a normal completion
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CPU_BUS;
            ADE       <= 1'b1;
            dma_grant <= 1'b0;
            preempt   <= 1'b0;
            burst_cnt <= 8'd0;
            cool_cnt  <= 8'd0;
        end else begin
            state     <= next_state;
            ADE       <= next_state == CPU_BUS;
            dma_grant <= next_state == DMA_BUS;
            preempt   <= state == DMA_BUS && burst_end && !dma_done && dma_req;
            burst_cnt <= (state == DMA_BUS) ? burst_cnt + 8'd1 : 8'd0;
            cool_cnt  <= (state == RETURN) ? COOL_LOAD :
                         (state == CPU_BUS && cool_cnt != 8'd0) ? cool_cnt - 8'd1 : cool_cnt;
        end
    end
endmodule
